// File: rtl/round_ctrl.sv
// Game-round controller for the binary number game: arms the seconds timer, judges guesses,
// keeps score and level. Define HINT_EN to build the registered guess-above/below hint outputs.
module round_ctrl #(
    parameter int unsigned START_TIME = 20,
    parameter int unsigned TIME_STEP  = 2,
    parameter int unsigned MIN_TIME   = 5,
    parameter int unsigned MAX_LEVEL  = 7,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       submit_btn,
    input  logic [7:0] sw,
    input  logic       end_f,
    input  logic [4:0] timeleft,
    output logic       timer_set_f,
    output logic [4:0] timer_set_v,
    output logic [7:0] target,
    output logic [7:0] score,
    output logic [2:0] level,
    output logic       playing,
    output logic       win_led,
    output logic       lose_led,
    output logic       cmp_hi,
    output logic       cmp_lo
);
    localparam int unsigned DW = 8;
    localparam int unsigned TW = 5;
    localparam int unsigned LW = 3;
    localparam int unsigned PW = 16;

    typedef enum logic [2:0] {IDLE, ARM, PLAY, WIN, OVER} state_t;

    state_t        state, state_d;
    logic          start_q, submit_q, btn_en;
    logic          start_e, submit_e;
    logic [DW-1:0] lfsr, lfsr_d;
    logic          arm_cnt, arm_cnt_d;
    logic [DW-1:0] target_d, score_d;
    logic [LW-1:0] level_d, level_inc;
    logic [TW-1:0] timer_set_v_d, round_time;
    logic          timer_set_f_d;
    logic [PW-1:0] lvl_prod;
    logic [DW:0]   score_sum;

    // btn_en masks the first cycle after reset so a button held through release is not an edge
    assign start_e  = btn_en & start_btn & ~start_q;
    assign submit_e = btn_en & submit_btn & ~submit_q;

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1; maximal length, so a nonzero seed never reaches 0
    assign lfsr_d = {lfsr[DW-2:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    assign lvl_prod   = PW'(level) * PW'(TIME_STEP);
    assign round_time = (lvl_prod > PW'(START_TIME - MIN_TIME)) ? TW'(MIN_TIME)
                                                                : TW'(PW'(START_TIME) - lvl_prod);

    assign score_sum = {1'b0, score} + (DW + 1)'(1) + (DW + 1)'(timeleft[4:2]);
    assign level_inc = (level >= LW'(MAX_LEVEL)) ? LW'(MAX_LEVEL) : level + LW'(1);

    always_comb begin
        state_d       = state;
        arm_cnt_d     = arm_cnt;
        target_d      = target;
        score_d       = score;
        level_d       = level;
        timer_set_v_d = timer_set_v;
        timer_set_f_d = timer_set_f;
        case (state)
            IDLE, OVER: begin
                if (start_e) begin
                    state_d       = ARM;
                    arm_cnt_d     = 1'b0;
                    score_d       = '0;
                    level_d       = '0;
                    target_d      = lfsr;
                    timer_set_v_d = TW'(START_TIME);
                    timer_set_f_d = 1'b1;
                end
            end
            ARM: begin
                if (arm_cnt) begin
                    state_d       = PLAY;
                    timer_set_f_d = 1'b0;
                end else begin
                    arm_cnt_d = 1'b1;
                end
            end
            PLAY: begin
                if (end_f) begin
                    state_d = OVER;
                end else if (submit_e) begin
                    if (sw == target) begin
                        state_d = WIN;
                        score_d = score_sum[DW] ? {DW{1'b1}} : score_sum[DW-1:0];
                        level_d = level_inc;
                    end else begin
                        state_d = OVER;
                    end
                end
            end
            WIN: begin
                // round_time already reflects the level raised on entry to WIN
                if (submit_e) begin
                    state_d       = ARM;
                    arm_cnt_d     = 1'b0;
                    target_d      = lfsr;
                    timer_set_v_d = round_time;
                    timer_set_f_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            lfsr        <= LFSR_SEED;
            start_q     <= 1'b0;
            submit_q    <= 1'b0;
            btn_en      <= 1'b0;
            arm_cnt     <= 1'b0;
            target      <= '0;
            score       <= '0;
            level       <= '0;
            timer_set_f <= 1'b0;
            timer_set_v <= TW'(START_TIME);
            playing     <= 1'b0;
            win_led     <= 1'b0;
            lose_led    <= 1'b0;
        end else begin
            state       <= state_d;
            lfsr        <= lfsr_d;
            start_q     <= start_btn;
            submit_q    <= submit_btn;
            btn_en      <= 1'b1;
            arm_cnt     <= arm_cnt_d;
            target      <= target_d;
            score       <= score_d;
            level       <= level_d;
            timer_set_f <= timer_set_f_d;
            timer_set_v <= timer_set_v_d;
            playing     <= (state_d == ARM) || (state_d == PLAY);
            win_led     <= (state_d == WIN);
            lose_led    <= (state_d == OVER);
        end
    end

`ifdef HINT_EN
    // Hints track the guess only while staying in PLAY and clear on the way out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_hi <= 1'b0;
            cmp_lo <= 1'b0;
        end else begin
            cmp_hi <= (state == PLAY) && (state_d == PLAY) && (sw > target);
            cmp_lo <= (state == PLAY) && (state_d == PLAY) && (sw < target);
        end
    end
`else
    assign cmp_hi = 1'b0;
    assign cmp_lo = 1'b0;
`endif

endmodule

// File: tb/tb_round_ctrl.sv
// Randomized scoreboard bench for round_ctrl; a second instance with START_TIME=12 shares
// every input so the round-time floor is checked alongside the default configuration.
module tb_round_ctrl;
    localparam int START_A = 20;
    localparam int START_B = 12;
    localparam int STEP    = 2;
    localparam int MINT    = 5;
    localparam int MAXL    = 7;
    localparam logic [7:0] SEED = 8'hA5;
    localparam int KIND_ARM  = 0;
    localparam int KIND_WIN  = 1;
    localparam int KIND_OVER = 2;
`ifdef HINT_EN
    localparam bit HINT = 1'b1;
`else
    localparam bit HINT = 1'b0;
`endif

    typedef struct {
        int kind;
        int tgt;
        int tsv_a;
        int tsv_b;
        int score;
        int level;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_btn = 1'b0;
    logic       submit_btn = 1'b0;
    logic       end_f = 1'b0;
    logic [7:0] sw = 8'd0;
    logic [4:0] timeleft = 5'd0;

    logic       tsf_a, playing_a, win_a, lose_a, hi_a, lo_a;
    logic [4:0] tsv_a;
    logic [7:0] target_a, score_a;
    logic [2:0] level_a;
    logic       tsf_b, playing_b, win_b, lose_b, hi_b, lo_b;
    logic [4:0] tsv_b;
    logic [7:0] target_b, score_b;
    logic [2:0] level_b;

    int   checks = 0;
    int   failures = 0;
    exp_t expq[$];
    logic [7:0] seq [0:254];
    int   cyc = 0;
    int   m_score = 0, m_level = 0, m_target = 0;

    round_ctrl dut (
        .clk(clk), .rst(rst), .start_btn(start_btn), .submit_btn(submit_btn), .sw(sw),
        .end_f(end_f), .timeleft(timeleft), .timer_set_f(tsf_a), .timer_set_v(tsv_a),
        .target(target_a), .score(score_a), .level(level_a), .playing(playing_a),
        .win_led(win_a), .lose_led(lose_a), .cmp_hi(hi_a), .cmp_lo(lo_a)
    );

    round_ctrl #(.START_TIME(12)) dut_b (
        .clk(clk), .rst(rst), .start_btn(start_btn), .submit_btn(submit_btn), .sw(sw),
        .end_f(end_f), .timeleft(timeleft), .timer_set_f(tsf_b), .timer_set_v(tsv_b),
        .target(target_b), .score(score_b), .level(level_b), .playing(playing_b),
        .win_led(win_b), .lose_led(lose_b), .cmp_hi(hi_b), .cmp_lo(lo_b)
    );

    always #5 clk = ~clk;

    // Clock cycles since reset release; the LFSR value is seq[cyc mod 255]
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & 8'hB8)};
    endfunction

    function automatic int round_time(input int st, input int lvl);
        if (lvl * STEP > st - MINT) return MINT;
        return st - lvl * STEP;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expectation per ARM entry, WIN entry or OVER entry
    logic p_tsf = 1'b0, p_win = 1'b0, p_lose = 1'b0;
    int   arm_len = 0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            p_tsf = 1'b0; p_win = 1'b0; p_lose = 1'b0; arm_len = 0;
        end else begin
            if (tsf_a && !p_tsf) begin
                chk("arm_expected", int'(expq.size() > 0), 1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk("arm_kind", KIND_ARM, e.kind);
                    chk("arm_target", int'(target_a), e.tgt);
                    chk("arm_target_b", int'(target_b), e.tgt);
                    chk("arm_target_nonzero", int'(target_a != 8'd0), 1);
                    chk("arm_tsv", int'(tsv_a), e.tsv_a);
                    chk("arm_tsv_floor", int'(tsv_b), e.tsv_b);
                    chk("arm_score", int'(score_a), e.score);
                    chk("arm_level", int'(level_a), e.level);
                    chk("arm_score_b", int'(score_b), e.score);
                    chk("arm_level_b", int'(level_b), e.level);
                end
            end
            if (win_a && !p_win) begin
                chk("win_expected", int'(expq.size() > 0), 1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk("win_kind", KIND_WIN, e.kind);
                    chk("win_score", int'(score_a), e.score);
                    chk("win_level", int'(level_a), e.level);
                    chk("win_not_playing", int'(playing_a), 0);
                end
            end
            if (lose_a && !p_lose) begin
                chk("over_expected", int'(expq.size() > 0), 1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk("over_kind", KIND_OVER, e.kind);
                    chk("over_score", int'(score_a), e.score);
                    chk("over_level", int'(level_a), e.level);
                    chk("over_not_playing", int'(playing_a), 0);
                end
            end
            if (tsf_a) begin
                arm_len++;
                chk("arm_playing", int'(playing_a), 1);
            end else if (p_tsf) begin
                chk("arm_len", arm_len, 2);
                chk("play_after_arm", int'(playing_a), 1);
                arm_len = 0;
            end
            p_tsf = tsf_a; p_win = win_a; p_lose = lose_a;
        end
    end

    task automatic check_reset_vals();
        chk("rst_tsf", int'(tsf_a), 0);
        chk("rst_tsv", int'(tsv_a), START_A);
        chk("rst_tsv_b", int'(tsv_b), START_B);
        chk("rst_target", int'(target_a), 0);
        chk("rst_score", int'(score_a), 0);
        chk("rst_level", int'(level_a), 0);
        chk("rst_playing", int'(playing_a), 0);
        chk("rst_win", int'(win_a), 0);
        chk("rst_lose", int'(lose_a), 0);
        chk("rst_hi", int'(hi_a), 0);
        chk("rst_lo", int'(lo_a), 0);
    endtask

    task automatic pulse_start(input bit inject);
        exp_t e;
        e.kind = KIND_ARM; e.tgt = int'(seq[cyc % 255]);
        e.tsv_a = START_A; e.tsv_b = START_B; e.score = 0; e.level = 0;
        expq.push_back(e);
        m_score = 0; m_level = 0; m_target = e.tgt;
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        if (inject) begin
            end_f = 1'b1; submit_btn = 1'b1;
            tick();
            end_f = 1'b0; submit_btn = 1'b0;
        end
    endtask

    task automatic wait_play();
        for (int i = 0; i < 20 && !(playing_a && !tsf_a); i++) tick();
        chk("reach_play", int'(playing_a && !tsf_a), 1);
    endtask

    // action: 0 correct, 1 wrong, 2 timeout, 3 timeout with a correct submit
    task automatic play_round(input int action, input int tl);
        exp_t e;
        timeleft = 5'(tl);
        e.kind = KIND_OVER;
        case (action)
            0: begin
                sw = 8'(m_target); submit_btn = 1'b1;
                m_score = (m_score + 1 + tl / 4 > 255) ? 255 : m_score + 1 + tl / 4;
                m_level = (m_level + 1 > MAXL) ? MAXL : m_level + 1;
                e.kind = KIND_WIN;
            end
            1: begin
                sw = 8'(m_target) ^ 8'($urandom_range(1, 255)); submit_btn = 1'b1;
            end
            2: end_f = 1'b1;
            default: begin
                sw = 8'(m_target); submit_btn = 1'b1; end_f = 1'b1;
            end
        endcase
        e.tgt = m_target; e.tsv_a = 0; e.tsv_b = 0; e.score = m_score; e.level = m_level;
        expq.push_back(e);
        tick();
        submit_btn = 1'b0; end_f = 1'b0;
    endtask

    task automatic win_continue(input bit noise);
        exp_t e;
        if (noise) begin
            end_f = 1'b1; start_btn = 1'b1;
            tick();
            end_f = 1'b0; start_btn = 1'b0;
        end
        tick();
        e.kind = KIND_ARM; e.tgt = int'(seq[cyc % 255]);
        e.tsv_a = round_time(START_A, m_level); e.tsv_b = round_time(START_B, m_level);
        e.score = m_score; e.level = m_level;
        expq.push_back(e);
        m_target = e.tgt;
        submit_btn = 1'b1;
        tick();
        submit_btn = 1'b0;
    endtask

    task automatic over_noise();
        tick();
        submit_btn = 1'b1; end_f = 1'b1;
        tick();
        submit_btn = 1'b0; end_f = 1'b0;
        tick();
    endtask

    task automatic hint_step(input int delta);
        logic [7:0] s;
        s = 8'(m_target + delta);
        sw = s;
        tick();
        chk("hint_hi", int'(hi_a), int'((s > 8'(m_target)) && HINT));
        chk("hint_lo", int'(lo_a), int'((s < 8'(m_target)) && HINT));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin : main
        seq[0] = SEED;
        for (int i = 1; i < 255; i++) seq[i] = lfsr_next(seq[i-1]);
        #1 rst = 1'b1;
        #1 check_reset_vals();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        pulse_start(1'b0);
        wait_play();
        play_round(0, 13);
        chk("first_win_score", int'(score_a), 4);
        chk("first_win_level", int'(level_a), 1);
        win_continue(1'b0);
        chk("second_round_tsv", int'(tsv_a), 18);

        // Long win streak with full time left: level and score both saturate
        for (int r = 0; r < 34; r++) begin
            wait_play();
            play_round(0, 31);
            win_continue(r % 3 == 0);
        end
        chk("streak_level", int'(level_a), 7);
        chk("streak_tsv", int'(tsv_a), 6);
        chk("streak_tsv_floor", int'(tsv_b), 5);
        chk("streak_score_sat", int'(score_a), 255);

        wait_play();
        play_round(3, 31);
        chk("endf_beats_submit_lose", int'(lose_a), 1);
        chk("endf_beats_submit_score", int'(score_a), 255);
        over_noise();
        pulse_start(1'b0);
        chk("restart_score", int'(score_a), 0);
        chk("restart_level", int'(level_a), 0);
        chk("restart_tsf", int'(tsf_a), 1);

        wait_play();
        play_round(1, 7);
        chk("wrong_guess_lose", int'(lose_a), 1);
        over_noise();
        pulse_start(1'b1);

        for (int r = 0; r < 40; r++) begin
            int act, tl;
            wait_play();
            repeat ($urandom_range(0, 3)) tick();
            act = $urandom_range(0, 3);
            tl  = $urandom_range(0, 31);
            play_round(act, tl);
            if (act == 0) win_continue($urandom_range(0, 1) == 1);
            else begin
                over_noise();
                pulse_start($urandom_range(0, 1) == 1);
            end
        end

        wait_play();
        hint_step(1);
        hint_step(-1);
        hint_step(0);

        // Reset mid-round, with start held high across the release
        chk("queue_drained_before_reset", expq.size(), 0);
        rst = 1'b1;
        #1 check_reset_vals();
        start_btn = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("held_start_no_arm", int'(tsf_a), 0);
            chk("held_start_idle", int'(playing_a), 0);
        end
        start_btn = 1'b0;
        tick();
        pulse_start(1'b0);
        wait_play();
        play_round(0, $urandom_range(0, 31));
        win_continue(1'b0);
        wait_play();
        repeat (5) tick();
        chk("queue_drained_at_end", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
